vec3_alu_pipe: RTL
==================

// Module: vec3_alu_pipe
// PURPOSE
//  Pipelined fixed-point vec3 ALU for the ray-marcher datapath. Accepts two vec3
//  operands plus an opcode per transaction; returns ADD/SUB/NEG/SCALE/DOT/CROSS results
//  after a fixed 3-cycle latency. Uses valid/ready handshakes on both sides, with full
//  backpressure. Carries an opaque tag so the ray-step FSM can match results to rays.
// PARAMETERS
//  DATA_WIDTH  32  element width, signed two's complement
//  FRAC_BITS   16  fractional bits (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS)
//  TAG_WIDTH    8  width of pass-through tag
// PORTS
//  clk        in   1             clock, all logic rising-edge
//  rst        in   1             synchronous reset, active-high
//  in_valid   in   1             operand transaction valid
//  in_ready   out  1             block can accept this cycle
//  in_op      in   3             0 ADD, 1 SUB, 2 NEG(a), 3 SCALE(a*b.x), 4 DOT, 5 CROSS, 6-7 illegal
//  in_a       in   3*DATA_WIDTH  vec3 a; x=[W-1:0], y=[2W-1:W], z=[3W-1:2W]
//  in_b       in   3*DATA_WIDTH  vec3 b, same packing
//  in_tag     in   TAG_WIDTH     opaque tag, returned unchanged
//  out_valid  out  1             result valid
//  out_ready  in   1             consumer accepts result
//  out_res    out  3*DATA_WIDTH  vec3 result, same packing; DOT -> scalar in x, y=z=0
//  out_tag    out  TAG_WIDTH     tag of this result
//  out_err    out  1             illegal opcode (res forced to 0)
//  out_sat    out  1             any element clipped (always 0 without SATURATE_EN)
// BEHAVIOUR
//  - Reset (rst=1 at edge): all stage valids, out_valid, out_err, out_sat <= 0; out_res,
//    out_tag <= 0. rst wins over every other event; in-flight ops are dropped, never emitted.
//  - Pipeline: S1 registers operands/op/tag and forms all full-width 2W products;
//    S2 applies >>> FRAC_BITS (floor, arithmetic) and sums/differences in W+2 bits;
//    S3 narrows to W (wrap or saturate) and drives the outputs.
//  - advance = !out_valid | out_ready; in_ready = advance (combinational).
//    On !advance all stages hold. Accept = in_valid & in_ready.
//  - Latency: an op accepted at edge N drives out_valid=1 after edge N+3 when no stall
//    occurs. Each stall cycle adds one cycle. Throughput is 1 op/cycle.
//  - out_* stay stable while out_valid & !out_ready. Result order equals accept order.
//  - Bubbles: stage valid=0 entries advance freely; a bubble never asserts out_valid.
//  - Arithmetic: ADD/SUB are element-wise in W+1 bits. NEG computes 0-a.
//    SCALE computes (a.e*b.x)>>>F per element. DOT computes sum of (a.e*b.e)>>>F,
//    each term shifted before summing. CROSS computes
//    (ay*bz-az*by, az*bx-ax*bz, ax*by-ay*bx), each product shifted before subtracting.
//  - Default narrowing takes the low W bits (wrap). NEG of the minimum value returns the
//    minimum value.
//  - Illegal op: out_res=0, out_err=1, out_sat=0; the result is emitted with normal timing
//    and tag.
// CONFIGURATION
//  VEC3_ALU_SATURATE_EN defined: narrowing clamps each element to
//    [-2^(W-1), 2^(W-1)-1]; out_sat=1 if any element clamped. The clamp applies to wide
//    products/sums before narrowing, so NEG(min) returns max.
//  Undefined: wrap as above; out_sat tied 0; no clamp logic is generated.
// TESTING (F=16, 1.0=0x00010000)
//  - DOT a=(1,2,3) b=(4,5,6), out_ready=1 -> x=0x00200000 (32.0), y=z=0, valid exactly 3 cyc
//    after accept, tag echoed.
//  - SCALE a=(1.5,-2,0.25) b.x=2.0 -> (0x00030000,0xFFFC0000,0x00008000); SCALE a.x=0xFFFFFFFF
//    by 0.5 -> 0xFFFFFFFF (floor).
//  - CROSS (1,0,0)x(0,1,0) -> (0,0,0x00010000); op=7 -> res=0, out_err=1.
//  - ADD 0x7FFFFFFF + 0x00000001: default -> 0x80000000, sat=0; with SATURATE_EN
//    -> 0x7FFFFFFF, sat=1.
//  - Backpressure: issue 4 back-to-back tagged ops, hold out_ready=0 for 5 cyc
//    -> in_ready=0 while full, out_* stable, then 4 results drain in order, none lost or
//    duplicated.
//  - Reset mid-flight: rst=1 for 1 cyc with 3 ops in flight -> out_valid=0 next cyc,
//    no stale result ever appears, next op has normal latency.

Source files
------------

// File: rtl/vec3_alu_pipe.sv
// vec3_alu_pipe: pipelined fixed-point vec3 ALU for the ray-marcher datapath.
// Computes ADD/SUB/NEG/SCALE/DOT/CROSS on two packed vec3 operands and returns
// the result with its tag four register stages later. The pipeline uses a single
// global enable, so a stalled output freezes every stage.
// Optional build macro: VEC3_ALU_SATURATE_EN (clamp on narrowing instead of wrap).
module vec3_alu_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_op,
    input  logic [3*DATA_WIDTH-1:0] in_a,
    input  logic [3*DATA_WIDTH-1:0] in_b,
    input  logic [TAG_WIDTH-1:0]    in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3*DATA_WIDTH-1:0] out_res,
    output logic [TAG_WIDTH-1:0]    out_tag,
    output logic                    out_err,
    output logic                    out_sat
);

    localparam int W  = DATA_WIDTH;
    // Wide result width: holds a sum of three shifted full products without loss,
    // so the saturating build can clamp on the true value.
    localparam int WR = 2 * W + 2;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_NEG   = 3'd2,
        OP_SCALE = 3'd3,
        OP_DOT   = 3'd4,
        OP_CROSS = 3'd5
    } op_e;

    function automatic logic [W-1:0] elem(input logic [3*W-1:0] v, input int i);
        return v[i*W +: W];
    endfunction

    function automatic logic signed [2*W-1:0] mul_full(input logic [W-1:0] x,
                                                       input logic [W-1:0] y);
        logic signed [2*W-1:0] ex;
        logic signed [2*W-1:0] ey;
        ex = {{W{x[W-1]}}, x};
        ey = {{W{y[W-1]}}, y};
        return ex * ey;
    endfunction

    function automatic logic signed [WR-1:0] ext_w(input logic [W-1:0] x);
        return {{(WR-W){x[W-1]}}, x};
    endfunction

    // Floor-scales a full product back to FRAC_BITS and widens it.
    function automatic logic signed [WR-1:0] ext_p(input logic signed [2*W-1:0] p);
        logic signed [2*W-1:0] s;
        s = p >>> FRAC_BITS;
        return {{(WR-2*W){s[2*W-1]}}, s};
    endfunction

    logic advance;
    logic accept;

    logic                  v1;
    logic [2:0]            op1;
    logic [3*W-1:0]        a1;
    logic [3*W-1:0]        b1;
    logic [TAG_WIDTH-1:0]  tag1;

    logic                  v2;
    logic [2:0]            op2;
    logic [3*W-1:0]        a2;
    logic [3*W-1:0]        b2;
    logic [TAG_WIDTH-1:0]  tag2;
    logic signed [2*W-1:0] p2 [6];

    logic                  v3;
    logic                  err3;
    logic [TAG_WIDTH-1:0]  tag3;
    logic signed [WR-1:0]  w3 [3];

    logic [W-1:0]          mul_a [6];
    logic [W-1:0]          mul_b [6];
    logic signed [WR-1:0]  wide [3];
    logic                  illegal;
    logic [3*W-1:0]        res_c;
    logic                  sat_c;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && in_ready;

    // Stage 1: capture the accepted transaction (or a bubble) when the pipe moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            op1  <= '0;
            a1   <= '0;
            b1   <= '0;
            tag1 <= '0;
        end else if (advance) begin
            v1   <= accept;
            op1  <= in_op;
            a1   <= in_a;
            b1   <= in_b;
            tag1 <= in_tag;
        end
    end

    // Route stage-1 elements onto six shared multipliers according to the opcode.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            mul_a[i] = '0;
            mul_b[i] = '0;
        end
        case (op1)
            OP_SCALE: begin
                for (int i = 0; i < 3; i++) begin
                    mul_a[i] = elem(a1, i);
                    mul_b[i] = elem(b1, 0);
                end
            end
            OP_DOT: begin
                for (int i = 0; i < 3; i++) begin
                    mul_a[i] = elem(a1, i);
                    mul_b[i] = elem(b1, i);
                end
            end
            OP_CROSS: begin
                mul_a[0] = elem(a1, 1); mul_b[0] = elem(b1, 2);
                mul_a[1] = elem(a1, 2); mul_b[1] = elem(b1, 1);
                mul_a[2] = elem(a1, 2); mul_b[2] = elem(b1, 0);
                mul_a[3] = elem(a1, 0); mul_b[3] = elem(b1, 2);
                mul_a[4] = elem(a1, 0); mul_b[4] = elem(b1, 1);
                mul_a[5] = elem(a1, 1); mul_b[5] = elem(b1, 0);
            end
            default: begin
            end
        endcase
    end

    // Stage 2: register the full-width products alongside the raw operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2   <= 1'b0;
            op2  <= '0;
            a2   <= '0;
            b2   <= '0;
            tag2 <= '0;
            for (int i = 0; i < 6; i++) p2[i] <= '0;
        end else if (advance) begin
            v2   <= v1;
            op2  <= op1;
            a2   <= a1;
            b2   <= b1;
            tag2 <= tag1;
            for (int i = 0; i < 6; i++) p2[i] <= mul_full(mul_a[i], mul_b[i]);
        end
    end

    // Shift each product before combining, then form the wide per-element results.
    always_comb begin
        for (int i = 0; i < 3; i++) wide[i] = '0;
        illegal = 1'b0;
        case (op2)
            OP_ADD: for (int i = 0; i < 3; i++) wide[i] = ext_w(elem(a2, i)) + ext_w(elem(b2, i));
            OP_SUB: for (int i = 0; i < 3; i++) wide[i] = ext_w(elem(a2, i)) - ext_w(elem(b2, i));
            OP_NEG: for (int i = 0; i < 3; i++) wide[i] = -ext_w(elem(a2, i));
            OP_SCALE: for (int i = 0; i < 3; i++) wide[i] = ext_p(p2[i]);
            OP_DOT: wide[0] = ext_p(p2[0]) + ext_p(p2[1]) + ext_p(p2[2]);
            OP_CROSS: begin
                wide[0] = ext_p(p2[0]) - ext_p(p2[1]);
                wide[1] = ext_p(p2[2]) - ext_p(p2[3]);
                wide[2] = ext_p(p2[4]) - ext_p(p2[5]);
            end
            default: illegal = 1'b1;
        endcase
    end

    // Stage 3: register the wide results and the illegal-opcode flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3   <= 1'b0;
            err3 <= 1'b0;
            tag3 <= '0;
            for (int i = 0; i < 3; i++) w3[i] <= '0;
        end else if (advance) begin
            v3   <= v2;
            err3 <= illegal;
            tag3 <= tag2;
            for (int i = 0; i < 3; i++) w3[i] <= wide[i];
        end
    end

`ifdef VEC3_ALU_SATURATE_EN
    // Clamp any element whose wide value does not fit in W signed bits.
    always_comb begin
        res_c = '0;
        sat_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if ((&w3[i][WR-1:W-1]) || !(|w3[i][WR-1:W-1])) begin
                res_c[i*W +: W] = w3[i][W-1:0];
            end else begin
                sat_c = 1'b1;
                res_c[i*W +: W] = w3[i][WR-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end
        end
    end
`else
    logic unused_wide_hi;
    assign unused_wide_hi = ^{w3[0][WR-1:W], w3[1][WR-1:W], w3[2][WR-1:W]};

    // Wrap: keep only the low W bits of each element.
    always_comb begin
        res_c = {w3[2][W-1:0], w3[1][W-1:0], w3[0][W-1:0]};
        sat_c = 1'b0;
    end
`endif

    // Output register: holds while the consumer stalls, refills when the pipe moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_res   <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
            out_sat   <= 1'b0;
        end else if (advance) begin
            out_valid <= v3;
            out_res   <= res_c;
            out_tag   <= tag3;
            out_err   <= err3;
            out_sat   <= sat_c;
        end
    end

endmodule
